mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h40000000, base of the four timer registers on the data bus.
REQ-002 reset  input  1  asynchronous, active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 Address  input  32  byte address from the MEM stage, shared with data memory.
REQ-005 Write_data  input  32  store data.
REQ-006 MemRead  input  1  load strobe.
REQ-007 MemWrite  input  1  store strobe.
REQ-008 Read_data  output  32  load data, ORed with the data-memory output by the MEM stage.
REQ-009 irqout  output  1  level interrupt request to the pipeline control.

Function
REQ-010 The register map SHALL be:
- TH at BASE+0x0, R/W, reload value.
- TL at BASE+0x4, R/W, counter.
- TCON at BASE+0x8, R/W bits [2:0]; bits [31:3] read 0.
- SYSTICK at BASE+0x14, read-only.
REQ-011 TCON SHALL hold bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status.
REQ-012 Read_data SHALL be combinational: the addressed register when MemRead=1 and Address matches a mapped word; otherwise 32'h0, including unmapped and partial addresses.
REQ-013 A write SHALL occur on a rising clk when MemWrite=1 and Address exactly matches TH, TL or TCON.
- TCON writes take Write_data[2:0].
- Writes to SYSTICK and to unmapped addresses are ignored.
REQ-014 When TCON[0]=1 and no TL write occurs, TL SHALL increment by 1 each cycle, modulo 2^32.
REQ-015 When TCON[0]=1 and TL=32'hFFFFFFFF, the next edge SHALL load TL<=TH instead of incrementing.
- If TCON[1]=1 on that edge, TCON[2] is set to 1 on the same edge.
REQ-016 TCON[2] SHALL stay set until software writes TCON with bit2=0; overflow never clears it.
REQ-017 irqout SHALL equal TCON[2] & TCON[1], registered state only, with no combinational path from the bus inputs.
REQ-018 Simultaneous TL write and overflow: the write SHALL win, so TL=Write_data and no reload occurs.
- TCON[2] is still set if TCON[1]=1.
REQ-019 Simultaneous TCON write and overflow: the written value SHALL be loaded, and then OR-set bit2 if the newly written bit1=1 and bit0=1.
REQ-020 A TH write coinciding with overflow SHALL NOT affect the reload; the old TH is loaded.
REQ-021 SYSTICK SHALL increment by 1 every cycle regardless of TCON, wrapping 32'hFFFFFFFF->0.
REQ-022 With TCON[0]=0, TL SHALL hold its value apart from software writes.

Reset
REQ-023 While reset=1, TH, TL and SYSTICK SHALL be 32'h0, TCON 3'b000, and irqout 0, all applied asynchronously.
REQ-024 Reset asserted mid-count or with an interrupt pending SHALL clear all state immediately.
- Counting resumes only after software sets TCON[0].
REQ-025 On the first edge after reset deasserts, SYSTICK SHALL become 1.

Structure
REQ-026 A shared package SHALL hold the register offsets (TH 0x0, TL 0x4, TCON 0x8, SYSTICK 0x14) and the TCON bit indices.
- The same offsets are used by the data-memory decoder and the software headers.
REQ-027 A single sub-module reload_counter SHALL implement:
- the 32-bit TL load/increment/reload, with inputs en, ld, ld_val, reload_val;
- output of the count and a terminal-count flag.
REQ-028 The rest (decode, TCON, SYSTICK, read mux) SHALL live in mmio_timer; no other sub-modules.

Verification
REQ-029 Basic reload:
- Stimulus: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011.
- Response: TL reads FFFFFFFF then FFFFFFFC on consecutive cycles; irqout rises on the reload edge and stays 1.
REQ-030 Interrupt clear:
- Stimulus: with irqout=1, write TCON=3'b011.
- Response: irqout=0 the next cycle; it re-asserts 4 cycles after the reload (FFFFFFFC->FFFFFFFF->reload).
REQ-031 Interrupt masked:
- Stimulus: write TCON=3'b001, TL=32'hFFFFFFFF.
- Response: TL reloads; TCON reads 32'h1; irqout stays 0.
REQ-032 Write/overflow collision:
- Stimulus: TL write of 32'h5 on the exact overflow edge with TCON=3'b011.
- Response: TL=5, TCON reads 32'h7, irqout=1.
REQ-033 Read isolation:
- Stimulus: MemRead=1 with Address=BASE+0xC, then with Address=0x00000010.
- Response: Read_data=0 in both cases; SYSTICK read returns the cycle count since reset.
REQ-034 Reset mid-operation:
- Stimulus: assert reset with TL=32'h1234 and irqout=1.
- Response: TL=0, TCON=0 and irqout=0 immediately, without a clock edge.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared register map and TCON bit layout for the MMIO timer.
// The same offsets are used by the data-memory decoder and the software headers.
package mmio_timer_pkg;

  localparam logic [31:0] OFS_TH      = 32'h0000_0000;
  localparam logic [31:0] OFS_TL      = 32'h0000_0004;
  localparam logic [31:0] OFS_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFS_SYSTICK = 32'h0000_0014;

  localparam int TCON_EN = 0;  // counter enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_IS = 2;  // interrupt status (sticky)

endpackage

// File: rtl/reload_counter.sv
// 32-bit up-counter with software load and automatic reload at terminal count.
// A load always takes priority over both increment and reload.
module reload_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        ld,
  input  logic [31:0] ld_val,
  input  logic [31:0] reload_val,
  output logic [31:0] count,
  output logic        tc
);

  assign tc = (count == 32'hFFFF_FFFF);

  // Count register: load, else reload at terminal count, else increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'h0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en) begin
      if (tc) count <= reload_val;
      else    count <= count + 32'h1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: TH reload, TL counter, TCON control/status, SYSTICK.
// Bus decode, TCON, SYSTICK and the read mux live here; TL is in reload_counter.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        reset,
  input  logic        clk,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        irqout
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic        tl_tc;
  logic        hit_th, hit_tl, hit_tcon, hit_systick;
  logic        wr_th, wr_tl, wr_tcon;
  logic        ovf;
  logic [2:0]  tcon_next;

  assign hit_th      = (Address == (BASE_ADDR + OFS_TH));
  assign hit_tl      = (Address == (BASE_ADDR + OFS_TL));
  assign hit_tcon    = (Address == (BASE_ADDR + OFS_TCON));
  assign hit_systick = (Address == (BASE_ADDR + OFS_SYSTICK));

  assign wr_th   = MemWrite & hit_th;
  assign wr_tl   = MemWrite & hit_tl;
  assign wr_tcon = MemWrite & hit_tcon;

  // Overflow is judged on the state before this edge, so a coincident write
  // to TH cannot change what gets reloaded.
  assign ovf = tcon[TCON_EN] & tl_tc;

  reload_counter u_tl (
    .clk        (clk),
    .reset      (reset),
    .en         (tcon[TCON_EN]),
    .ld         (wr_tl),
    .ld_val     (Write_data),
    .reload_val (th),
    .count      (tl),
    .tc         (tl_tc)
  );

  // TCON next value: a software write replaces the register, then overflow
  // may OR in the status bit (using the newly written enables on a collision).
  always_comb begin
    tcon_next = tcon;
    if (wr_tcon) begin
      tcon_next = Write_data[2:0];
      if (ovf && Write_data[TCON_IE] && Write_data[TCON_EN])
        tcon_next[TCON_IS] = 1'b1;
    end else if (ovf && tcon[TCON_IE]) begin
      tcon_next[TCON_IS] = 1'b1;
    end
  end

  // Software-visible registers and the free-running tick counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= 32'h0;
      tcon    <= 3'b000;
      systick <= 32'h0;
    end else begin
      if (wr_th) th <= Write_data;
      tcon    <= tcon_next;
      systick <= systick + 32'h1;
    end
  end

  // Interrupt is a pure function of registered TCON bits.
  assign irqout = tcon[TCON_IS] & tcon[TCON_IE];

  // Combinational read mux; anything not an exact mapped word reads zero.
  always_comb begin
    Read_data = 32'h0;
    if (MemRead) begin
      if (hit_th)           Read_data = th;
      else if (hit_tl)      Read_data = tl;
      else if (hit_tcon)    Read_data = {29'h0, tcon};
      else if (hit_systick) Read_data = systick;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with hand-computed expectations.
module tb_mmio_timer;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE + 32'h0;
  localparam logic [31:0] A_TL  = BASE + 32'h4;
  localparam logic [31:0] A_TC  = BASE + 32'h8;
  localparam logic [31:0] A_ST  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'h0;
  logic [31:0] Write_data = 32'h0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        irqout;

  int checks = 0;
  int errors = 0;
  int unsigned cyc;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .reset      (reset),
    .clk        (clk),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .irqout     (irqout)
  );

  always #5 clk = ~clk;

  // Reference cycle count since reset release.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address    = addr;
    Write_data = data;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Address    = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data    = Read_data;
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    chk(tag, d, exp);
  endtask

  logic [31:0] rd;

  initial begin
    // Reset values
    #2;
    chk("rst_irq", {31'h0, irqout}, 32'h0);
    chk_reg("rst_th", A_TH, 32'h0);
    chk_reg("rst_tl", A_TL, 32'h0);
    chk_reg("rst_tcon", A_TC, 32'h0);
    chk_reg("rst_systick", A_ST, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    chk_reg("systick_first", A_ST, 32'h1);

    // Basic reload
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TC, 32'h3);
    chk_reg("tl_after_en", A_TL, 32'hFFFF_FFFE);
    tick();
    chk_reg("tl_ffff", A_TL, 32'hFFFF_FFFF);
    chk("irq_before_reload", {31'h0, irqout}, 32'h0);
    tick();
    chk_reg("tl_reload", A_TL, 32'hFFFF_FFFC);
    chk("irq_on_reload", {31'h0, irqout}, 32'h1);
    chk_reg("tcon_set", A_TC, 32'h7);
    tick();
    chk("irq_stays", {31'h0, irqout}, 32'h1);
    chk_reg("tl_inc_after", A_TL, 32'hFFFF_FFFD);

    // Interrupt clear and re-assert
    bus_write(A_TC, 32'h3);
    chk("irq_cleared", {31'h0, irqout}, 32'h0);
    chk_reg("tl_e2", A_TL, 32'hFFFF_FFFE);
    tick();
    chk("irq_still_clear", {31'h0, irqout}, 32'h0);
    tick();
    chk_reg("tl_reload2", A_TL, 32'hFFFF_FFFC);
    chk("irq_reassert", {31'h0, irqout}, 32'h1);

    // TL write on the overflow edge
    bus_write(A_TC, 32'h3);
    tick();
    tick();
    chk_reg("tl_pre_coll", A_TL, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'h5);
    chk_reg("tl_coll", A_TL, 32'h5);
    chk_reg("tcon_coll", A_TC, 32'h7);
    chk("irq_coll", {31'h0, irqout}, 32'h1);
    tick();
    chk_reg("tl_after_coll", A_TL, 32'h6);

    // Interrupt masked
    bus_write(A_TC, 32'h1);
    bus_write(A_TL, 32'hFFFF_FFFF);
    tick();
    chk_reg("tl_masked_reload", A_TL, 32'hFFFF_FFFC);
    chk_reg("tcon_masked", A_TC, 32'h1);
    chk("irq_masked", {31'h0, irqout}, 32'h0);

    // TH write coinciding with overflow uses the old TH
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h0000_0100);
    chk_reg("tl_old_th", A_TL, 32'hFFFF_FFFC);
    chk_reg("th_new", A_TH, 32'h0000_0100);
    bus_write(A_TL, 32'hFFFF_FFFF);
    tick();
    chk_reg("tl_new_th", A_TL, 32'h0000_0100);

    // TCON write on the overflow edge
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TC, 32'h3);
    chk_reg("tcon_wr_ovf", A_TC, 32'h7);
    chk("irq_wr_ovf", {31'h0, irqout}, 32'h1);
    chk_reg("tl_wr_ovf", A_TL, 32'h0000_0100);
    bus_write(A_TC, 32'h1);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TC, 32'hFFFF_FFFA);
    chk_reg("tcon_dis_ovf", A_TC, 32'h2);
    chk_reg("tl_dis_ovf", A_TL, 32'h0000_0100);
    tick();
    chk_reg("tl_hold", A_TL, 32'h0000_0100);

    // Ignored writes and read isolation
    bus_write(A_ST, 32'h0);
    bus_write(BASE + 32'hC, 32'hDEAD_BEEF);
    bus_write(BASE + 32'h1, 32'hDEAD_BEEF);
    chk_reg("th_unmapped_wr", A_TH, 32'h0000_0100);
    chk_reg("tl_unmapped_wr", A_TL, 32'h0000_0100);
    chk_reg("rd_unmapped_c", BASE + 32'hC, 32'h0);
    chk_reg("rd_low_10", 32'h0000_0010, 32'h0);
    tick();
    chk_reg("rd_partial", BASE + 32'h1, 32'h0);
    Address = A_TH; MemRead = 1'b0; #1;
    chk("rd_no_strobe", Read_data, 32'h0);
    Address = 32'h0;
    tick();
    chk_reg("systick_count", A_ST, cyc);

    // Reset mid-operation
    bus_write(A_TC, 32'h0);
    bus_write(A_TL, 32'h1234);
    bus_write(A_TC, 32'h6);
    chk("irq_pre_rst", {31'h0, irqout}, 32'h1);
    chk_reg("tl_pre_rst", A_TL, 32'h1234);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("irq_async_rst", {31'h0, irqout}, 32'h0);
    chk_reg("tl_async_rst", A_TL, 32'h0);
    chk_reg("tcon_async_rst", A_TC, 32'h0);
    chk_reg("th_async_rst", A_TH, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk_reg("tl_idle_after_rst", A_TL, 32'h0);
    chk_reg("systick_after_rst", A_ST, 32'h2);
    bus_write(A_TC, 32'h1);
    tick();
    chk_reg("tl_resume", A_TL, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
